// File: rtl/instruction_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_pkg
//   Shared definitions for the fetch stage: FSM state encoding, opcode and
//   condition constants, flag bit names and the instruction field helpers.
//   Instruction layout (32-bit word):
//     [31:29] opcode
//     [28:26] condition (JMP) / sub-op / flag bit index (ATC)
//     [7:0]   branch target
// ---------------------------------------------------------------------------
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RESOLVE = 2'd2
    } fetch_state_e;

    // Opcodes
    localparam logic [2:0] OPC_NOP = 3'b000;
    localparam logic [2:0] OPC_JMP = 3'b110;
    localparam logic [2:0] OPC_ATC = 3'b111;

    // Jump conditions; everything other than UNC must be evaluated by execute
    localparam logic [2:0] COND_UNC = 3'b000;

    // Flag register bit indices
    localparam logic [2:0] FLAG_ZERO  = 3'd0;
    localparam logic [2:0] FLAG_CARRY = 3'd1;
    localparam logic [2:0] FLAG_NEG   = 3'd2;
    localparam logic [2:0] FLAG_OFLW  = 3'd3;

    // Field positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 29;
    localparam int SUB_MSB = 28;
    localparam int SUB_LSB = 26;
    localparam int TGT_MSB = 7;
    localparam int TGT_LSB = 0;

    function automatic logic [2:0] instr_opcode(input logic [31:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [2:0] instr_sub(input logic [31:0] instr);
        return instr[SUB_MSB:SUB_LSB];
    endfunction

    function automatic logic [7:0] instr_target(input logic [31:0] instr);
        return instr[TGT_MSB:TGT_LSB];
    endfunction

endpackage

// File: rtl/instruction_fetch_program_counter.sv
// ---------------------------------------------------------------------------
// program_counter
//   ADDR_W-bit program counter with synchronous active-low reset, parallel
//   load and increment. Load has priority over increment; increment wraps
//   modulo 2^ADDR_W.
// Ports:
//   clock          in   rising-edge clock
//   reset_n        in   synchronous active-low reset (pc <- RESET_PC)
//   load_i         in   load load_value_i this cycle
//   load_value_i   in   value to load
//   incr_i         in   increment pc this cycle (ignored when load_i)
//   pc_o           out  current program counter
// ---------------------------------------------------------------------------
module program_counter #(
    parameter int              ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_value_i,
    input  logic              incr_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_value_i;
        end else if (incr_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage sitting directly upstream of instruction memory. Owns the PC,
//   captures the returned word into the instruction register, offers it to
//   execute with a valid/ready handshake and resolves JMP/ATC to choose the
//   next PC. Conditional jumps whose condition is not yet known at accept
//   time park in RESOLVE until execute reports the outcome.
// Ports:
//   clock        in   rising-edge clock
//   reset_n      in   synchronous active-low reset
//   enable       in   run gate; only gates starting a new fetch
//   instr_addr   out  address to instruction memory (= pc)
//   instr_data   in   combinational word from instruction memory
//   ir           out  instruction register
//   ir_pc        out  address ir was fetched from
//   ir_valid     out  ir is offered to execute
//   ir_ready     in   execute accepts ir (accept = ir_valid & ir_ready)
//   cond_valid   in   condition of the current conditional JMP is known
//   cond_taken   in   condition outcome, meaningful with cond_valid
//   flags        in   flag register
//   flag_clr     out  one-cycle one-hot clear request after a taken ATC
// ---------------------------------------------------------------------------
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 32,
    parameter int                FLAG_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    output logic [ADDR_W-1:0]  instr_addr,
    input  logic [INSTR_W-1:0] instr_data,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               cond_valid,
    input  logic               cond_taken,
    input  logic [FLAG_W-1:0]  flags,
    output logic [FLAG_W-1:0]  flag_clr
);

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic [FLAG_W-1:0]  flag_clr_q, flag_clr_d;

    logic [ADDR_W-1:0]  pc;
    logic               pc_load;
    logic               pc_incr;
    logic [ADDR_W-1:0]  pc_target;

    logic [2:0]         opcode;
    logic [2:0]         sub;
    logic               accept;

    assign opcode    = instr_opcode(ir_q[31:0]);
    assign sub       = instr_sub(ir_q[31:0]);
    assign pc_target = ADDR_W'(instr_target(ir_q[31:0]));
    assign accept    = (state_q == ST_ISSUE) && ir_ready;

    program_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_program_counter (
        .clock        (clock),
        .reset_n      (reset_n),
        .load_i       (pc_load),
        .load_value_i (pc_target),
        .incr_i       (pc_incr),
        .pc_o         (pc)
    );

    // Next-state, next-PC selection and flag clear decode.
    // The PC is only ever moved when an instruction leaves the stage, so while
    // parked in RESOLVE it still equals ir_pc and pc+1 is the fall-through.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        flag_clr_d = '0;
        pc_load    = 1'b0;
        pc_incr    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (enable) begin
                    ir_d    = instr_data;
                    ir_pc_d = pc;
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (accept) begin
                    state_d = ST_FETCH;
                    if (opcode == OPC_JMP) begin
                        if (sub == COND_UNC) begin
                            pc_load = 1'b1;
                        end else if (cond_valid) begin
                            pc_load = cond_taken;
                            pc_incr = !cond_taken;
                        end else begin
                            state_d = ST_RESOLVE;
                        end
                    end else if (opcode == OPC_ATC) begin
                        if (flags[sub]) begin
                            pc_load    = 1'b1;
                            flag_clr_d = FLAG_W'(1) << sub;
                        end else begin
                            pc_incr = 1'b1;
                        end
                    end else begin
                        pc_incr = 1'b1;
                    end
                end
            end

            ST_RESOLVE: begin
                if (cond_valid) begin
                    state_d = ST_FETCH;
                    pc_load = cond_taken;
                    pc_incr = !cond_taken;
                end
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_FETCH;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            flag_clr_q <= '0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            flag_clr_q <= flag_clr_d;
        end
    end

    assign instr_addr = pc;
    assign ir         = ir_q;
    assign ir_pc      = ir_pc_q;
    assign ir_valid   = (state_q == ST_ISSUE);
    assign flag_clr   = flag_clr_q;

endmodule
